// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
//   Upstream feeder for systolic_array. Holds one N x N activation tile (A) and
//   one N x N weight tile (B), each as N lane-packed words. On start it streams
//   both tiles onto the array buses with diagonal skew: lane k of the output is
//   delayed k cycles relative to lane 0.
//
// Ports
//   clk          rising-edge system clock
//   reset        synchronous, active-high; clears FSM, outputs and both buffers
//   wr_en        buffer write strobe (honoured only while idle)
//   wr_sel       0 = A buffer, 1 = B buffer
//   wr_idx       word index 0..N-1
//   wr_data      lane-packed word, lane 0 in the top DW bits
//   start        single-cycle pulse to begin streaming (ignored while busy)
//   busy         stream in progress
//   done         one-cycle pulse after the last stream word
//   out_valid    datain_out / weightin_out carry a stream word
//   datain_out   skewed A stream to systolic_array datain
//   weightin_out skewed B stream to systolic_array weightin
module systolic_skew_feeder #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8,
    parameter int unsigned IW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [IW-1:0]   wr_idx,
    input  logic [N*DW-1:0] wr_data,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            out_valid,
    output logic [N*DW-1:0] datain_out,
    output logic [N*DW-1:0] weightin_out
);

    localparam int unsigned W  = N * DW;
    localparam int unsigned CW = (N > 1) ? $clog2(2 * N - 1) : 1;
    localparam logic [CW-1:0] LastStep = CW'(2 * N - 2);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load;
    logic          done_d;
    logic [W-1:0]  din_d, win_d;

    logic [W-1:0]  a_mem [N];
    logic [W-1:0]  b_mem [N];

    // Next-state and control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                load = 1'b1;
                if (cnt_q == LastStep) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Skewed word for step t = cnt_q: lane k reads word t-k when it lies in the tile,
    // otherwise the lane is zero. Outside RUN the whole word is zero.
    always_comb begin
        din_d = '0;
        win_d = '0;
        if (state_q == StRun) begin
            for (int k = 0; k < int'(N); k++) begin
                if ((int'(cnt_q) >= k) && ((int'(cnt_q) - k) < int'(N))) begin
                    din_d[W-1-k*DW -: DW] = a_mem[IW'(int'(cnt_q) - k)][W-1-k*DW -: DW];
                    win_d[W-1-k*DW -: DW] = b_mem[IW'(int'(cnt_q) - k)][W-1-k*DW -: DW];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            done         <= 1'b0;
            out_valid    <= 1'b0;
            datain_out   <= '0;
            weightin_out <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            done         <= done_d;
            out_valid    <= load;
            datain_out   <= din_d;
            weightin_out <= win_d;
        end
    end

    // Tile buffers: writes land only while idle, so a running stream sees a stable tile.
    // A write in the same cycle as start still commits before the first read.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(N); i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
            end
        end else if (wr_en && (state_q == StIdle)) begin
            if (wr_sel) begin
                b_mem[wr_idx] <= wr_data;
            end else begin
                a_mem[wr_idx] <= wr_data;
            end
        end
    end

    // Busy covers RUN and the DONE state (last valid word); it drops with the done pulse.
    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;
    localparam int W  = N * DW;
    localparam int S  = 2 * N - 1;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic          wr_sel;
    logic [IW-1:0] wr_idx;
    logic [W-1:0]  wr_data;
    logic          start;
    logic          busy;
    logic          done;
    logic          out_valid;
    logic [W-1:0]  datain_out;
    logic [W-1:0]  weightin_out;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] a_ref [N];
    logic [W-1:0] b_ref [N];
    logic [W-1:0] exp_d [$];
    logic [W-1:0] exp_w [$];

    systolic_skew_feeder #(
        .N  (N),
        .DW (DW),
        .IW (IW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_sel       (wr_sel),
        .wr_idx       (wr_idx),
        .wr_data      (wr_data),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .out_valid    (out_valid),
        .datain_out   (datain_out),
        .weightin_out (weightin_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference skew: lane k at step t carries word t-k of the tile, else zero.
    function automatic logic [W-1:0] skew(input logic [W-1:0] m [N], input int t);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if ((t - k >= 0) && (t - k < N)) begin
                r[W-1-k*DW -: DW] = m[IW'(t - k)][W-1-k*DW -: DW];
            end
        end
        return r;
    endfunction

    task automatic write_word(input bit sel, input int idx, input logic [W-1:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_idx  = IW'(idx);
        wr_data = data;
        tick();
        wr_en = 1'b0;
        if (sel) b_ref[idx] = data;
        else     a_ref[idx] = data;
    endtask

    // Pulses start, scores the whole stream, returns inside the done cycle.
    // disturb: write A1 and re-pulse start in the middle of the stream.
    task automatic run_stream(input string tag, input bit disturb, output logic [W-1:0] seen [S]);
        for (int t = 0; t < S; t++) begin
            exp_d.push_back(skew(a_ref, t));
            exp_w.push_back(skew(b_ref, t));
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        total++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || datain_out !== '0) begin
            bad++;
            $display("FAIL %s_launch: got busy=%b valid=%b din=%h want busy=1 valid=0 din=0",
                     tag, busy, out_valid, datain_out);
        end
        for (int c = 0; c < S; c++) begin
            if (disturb && c == 2) begin
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_idx  = IW'(1);
                wr_data = '1;
                start   = 1'b1;
            end
            tick();
            wr_en = 1'b0;
            start = 1'b0;
            seen[c] = datain_out;
            total++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL %s_valid[%0d]: got valid=%b busy=%b done=%b want 1 1 0",
                         tag, c, out_valid, busy, done);
            end
            total++;
            if (exp_d.size() == 0) begin
                bad++;
                $display("FAIL %s_sb[%0d]: got empty queue want entry", tag, c);
            end else begin
                logic [W-1:0] ed, ew;
                ed = exp_d.pop_front();
                ew = exp_w.pop_front();
                if (datain_out !== ed || weightin_out !== ew) begin
                    bad++;
                    $display("FAIL %s_word[%0d]: got din=%h win=%h want din=%h win=%h",
                             tag, c, datain_out, weightin_out, ed, ew);
                end
            end
        end
        tick();
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
            datain_out !== '0 || weightin_out !== '0) begin
            bad++;
            $display("FAIL %s_done: got done=%b busy=%b valid=%b din=%h win=%h want 1 0 0 0 0",
                     tag, done, busy, out_valid, datain_out, weightin_out);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            a_ref[i] = '0;
            b_ref[i] = '0;
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if ({busy, done, out_valid, datain_out, weightin_out} !== '0) begin
                bad++;
                $display("FAIL reset_idle[%0d]: got busy=%b done=%b valid=%b din=%h win=%h want 0",
                         c, busy, done, out_valid, datain_out, weightin_out);
            end
        end
    endtask

    task automatic test_stream();
        logic [W-1:0] seen [S];
        logic [W-1:0] tbl [S];
        tbl = '{32'h01000000, 32'h05020000, 32'h09060300, 32'h0D0A0704,
                32'h000E0B08, 32'h00000F0C, 32'h00000010};
        write_word(1'b0, 0, 32'h01020304);
        write_word(1'b0, 1, 32'h05060708);
        write_word(1'b0, 2, 32'h090A0B0C);
        write_word(1'b0, 3, 32'h0D0E0F10);
        write_word(1'b1, 0, 32'h11121314);
        write_word(1'b1, 1, 32'h15161718);
        write_word(1'b1, 2, 32'h191A1B1C);
        write_word(1'b1, 3, 32'h1D1E1F20);
        run_stream("ab", 1'b0, seen);
        for (int c = 0; c < S; c++) begin
            total++;
            if (seen[c] !== tbl[c]) begin
                bad++;
                $display("FAIL table[%0d]: got %h want %h", c, seen[c], tbl[c]);
            end
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_width: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] seen [S];
        run_stream("disturb", 1'b1, seen);
        tick();
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL no_restart: got busy=%b valid=%b want 0 0", busy, out_valid);
        end
        run_stream("rerun", 1'b0, seen);
        total++;
        if (seen[1] !== 32'h05020000) begin
            bad++;
            $display("FAIL a1_kept: got %h want %h", seen[1], 32'h05020000);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] seen [S];
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre: got valid=%b want 1", out_valid);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({busy, done, out_valid, datain_out, weightin_out} !== '0) begin
            bad++;
            $display("FAIL mid_reset: got busy=%b done=%b valid=%b din=%h win=%h want 0",
                     busy, done, out_valid, datain_out, weightin_out);
        end
        for (int i = 0; i < N; i++) begin
            a_ref[i] = '0;
            b_ref[i] = '0;
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL mid_nodone[%0d]: got done=%b busy=%b want 0 0", c, done, busy);
            end
        end
        run_stream("zero", 1'b0, seen);
    endtask

    // Entered in the done cycle of the previous stream.
    task automatic test_start_in_done();
        logic [W-1:0] seen [S];
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_idx  = '0;
        wr_data = 32'hAA000000;
        a_ref[0] = 32'hAA000000;
        run_stream("chain", 1'b0, seen);
        total++;
        if (seen[0] !== 32'hAA000000) begin
            bad++;
            $display("FAIL chain_first: got %h want %h", seen[0], 32'hAA000000);
        end
        tick();
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        start   = 1'b0;
        test_reset();
        test_stream();
        test_back_to_back();
        test_reset_mid();
        test_start_in_done();
        total++;
        if (exp_d.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d left want 0", exp_d.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
